// File: rtl/idct_mul_sched.sv
// idct_mul_sched
// Round-robin scheduler that time-shares one approximate multiplier wrapper
// between NREQ requesters of the IDCT datapath. It issues at most one operand
// pair per cycle through a registered issue stage and tags each product with
// its requester id. A first-word-fall-through result FIFO returns the products.
// Grants are credit-limited so that no product is ever dropped while the
// consumer stalls.
//
// Ports:
//   clk, rstP                 clock, synchronous active-high reset
//   req_valid / req_ready     per-requester handshake (ready is one-hot or zero)
//   req_a / req_b / req_mode  per-requester operands and precision code (slice i)
//   flush                     stop issuing and drain in-flight work
//   mul_a / mul_b / mul_state registered operands and precision code to wrapper
//   mul_count0                index (mod 64) of the op currently presented
//   mul_p                     wrapper product, valid MUL_LAT cycles after issue
//   rsp_valid/rsp_ready/rsp_id/rsp_p  result stream in issue order
//   busy                      in-flight or buffered work exists
//   drained                   one-cycle pulse when a flush completes
module idct_mul_sched #(
    parameter int NREQ               = 4,
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int MUL_LAT            = 2,
    parameter int IDW                = 3
) (
    input  logic                               clk,
    input  logic                               rstP,
    input  logic [NREQ-1:0]                    req_valid,
    output logic [NREQ-1:0]                    req_ready,
    input  logic [NREQ*DATA_PATH_BITWIDTH-1:0] req_a,
    input  logic [NREQ*DATA_PATH_BITWIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]                  req_mode,
    input  logic                               flush,
    output logic [DATA_PATH_BITWIDTH-1:0]      mul_a,
    output logic [DATA_PATH_BITWIDTH-1:0]      mul_b,
    output logic [2:0]                         mul_state,
    output logic [8:0]                         mul_count0,
    input  logic [31:0]                        mul_p,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [IDW-1:0]                     rsp_id,
    output logic [31:0]                        rsp_p,
    output logic                               busy,
    output logic                               drained
);

    localparam int DW    = DATA_PATH_BITWIDTH;
    localparam int DEPTH = MUL_LAT + 2;
    localparam int NSTG  = MUL_LAT + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              drained_q, drained_d;
    logic [IDW-1:0]    rr_ptr_q;
    logic [5:0]        issue_cnt_q;
    logic [DW-1:0]     mul_a_q, mul_b_q;
    logic [2:0]        mul_state_q;
    logic [8:0]        mul_count0_q;
    logic [NSTG-1:0]   tag_vld_q;
    logic [IDW-1:0]    tag_id_q [NSTG];
    logic [IDW-1:0]    fifo_id_q [DEPTH];
    logic [31:0]       fifo_p_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     fifo_cnt_q;

    logic              gnt_any_s;
    logic [IDW-1:0]    gnt_id_s;
    logic [IDW-1:0]    gnt_nxt_ptr_s;
    logic [DW-1:0]     gnt_a_s, gnt_b_s;
    logic [2:0]        gnt_mode_s;
    logic              credit_ok_s;
    int                inflight_s;
    logic              push_s, pop_s, fifo_nonempty_s, pipe_empty_s, enter_idle_s;

    assign fifo_nonempty_s = (fifo_cnt_q != {CW{1'b0}});
    assign push_s          = tag_vld_q[NSTG-1];
    assign pop_s           = fifo_nonempty_s & rsp_ready;
    assign pipe_empty_s    = (tag_vld_q == {NSTG{1'b0}}) & ~fifo_nonempty_s;
    assign enter_idle_s    = (state_d == S_IDLE) & (state_q != S_IDLE);

    // Credit check: a FIFO slot freed by this cycle's pop may be reused by
    // this cycle's grant, which is what sustains one op per cycle.
    always_comb begin
        inflight_s = 0;
        for (int s = 0; s < NSTG; s++) begin
            inflight_s = inflight_s + (tag_vld_q[s] ? 1 : 0);
        end
        credit_ok_s = ((DEPTH - int'(fifo_cnt_q) - inflight_s + (pop_s ? 1 : 0)) > 0);
    end

    // Round-robin arbiter: scan downward so the last hit is the lowest
    // offset from rr_ptr, i.e. the winner.
    always_comb begin
        int idx;
        idx           = 0;
        gnt_any_s     = 1'b0;
        gnt_id_s      = {IDW{1'b0}};
        if ((state_q == S_RUN) && !flush && credit_ok_s) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx       = (int'(rr_ptr_q) + k) % NREQ;
                gnt_id_s  = req_valid[idx] ? IDW'(idx) : gnt_id_s;
                gnt_any_s = gnt_any_s | req_valid[idx];
            end
        end else begin
            gnt_any_s = 1'b0;
        end
        gnt_a_s       = req_a[int'(gnt_id_s)*DW +: DW];
        gnt_b_s       = req_b[int'(gnt_id_s)*DW +: DW];
        gnt_mode_s    = req_mode[int'(gnt_id_s)*3 +: 3];
        gnt_nxt_ptr_s = (int'(gnt_id_s) == NREQ - 1) ? {IDW{1'b0}} : gnt_id_s + IDW'(1);
        req_ready     = gnt_any_s ? (NREQ'(1) << gnt_id_s) : {NREQ{1'b0}};
    end

    // FSM next state and drain-complete pulse.
    always_comb begin
        state_d   = state_q;
        drained_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush)           state_d = S_FLUSH;
                else if (|req_valid) state_d = S_RUN;
                else                 state_d = S_IDLE;
            end
            S_RUN: begin
                if (flush)                            state_d = S_FLUSH;
                else if (!(|req_valid) && pipe_empty_s) state_d = S_IDLE;
                else                                  state_d = S_RUN;
            end
            S_FLUSH: begin
                if (pipe_empty_s) begin
                    state_d   = S_IDLE;
                    drained_d = 1'b1;
                end else begin
                    state_d   = S_FLUSH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, drained pulse and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rstP) begin
            state_q   <= S_IDLE;
            drained_q <= 1'b0;
            rr_ptr_q  <= {IDW{1'b0}};
        end else begin
            state_q   <= state_d;
            drained_q <= drained_d;
            rr_ptr_q  <= gnt_any_s ? gnt_nxt_ptr_s : rr_ptr_q;
        end
    end

    // Issue register: operands of the granted op, zeros when nothing issues.
    // mul_count0 tracks the index of the op being presented.
    always_ff @(posedge clk) begin
        if (rstP || enter_idle_s) begin
            mul_a_q      <= {DW{1'b0}};
            mul_b_q      <= {DW{1'b0}};
            mul_state_q  <= 3'b000;
            mul_count0_q <= 9'd0;
            issue_cnt_q  <= 6'd0;
        end else if (gnt_any_s) begin
            mul_a_q      <= gnt_a_s;
            mul_b_q      <= gnt_b_s;
            mul_state_q  <= gnt_mode_s;
            mul_count0_q <= {3'b000, issue_cnt_q};
            issue_cnt_q  <= issue_cnt_q + 6'd1;
        end else begin
            mul_a_q      <= {DW{1'b0}};
            mul_b_q      <= {DW{1'b0}};
            mul_state_q  <= 3'b000;
        end
    end

    // Tag pipe: the last stage lines up with a valid mul_p.
    always_ff @(posedge clk) begin
        if (rstP) begin
            tag_vld_q <= {NSTG{1'b0}};
            for (int s = 0; s < NSTG; s++) tag_id_q[s] <= {IDW{1'b0}};
        end else begin
            tag_vld_q[0] <= gnt_any_s;
            tag_id_q[0]  <= gnt_id_s;
            for (int s = 1; s < NSTG; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

    // Result FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rstP) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            fifo_cnt_q <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_q <= (int'(wr_ptr_q) == DEPTH - 1) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
            else        wr_ptr_q <= wr_ptr_q;
            if (pop_s)  rd_ptr_q <= (int'(rd_ptr_q) == DEPTH - 1) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
            else        rd_ptr_q <= rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Result FIFO storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_id_q[wr_ptr_q] <= tag_id_q[NSTG-1];
            fifo_p_q[wr_ptr_q]  <= mul_p;
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_state  = mul_state_q;
    assign mul_count0 = mul_count0_q;
    assign rsp_valid  = fifo_nonempty_s;
    assign rsp_id     = fifo_nonempty_s ? fifo_id_q[rd_ptr_q] : {IDW{1'b0}};
    assign rsp_p      = fifo_nonempty_s ? fifo_p_q[rd_ptr_q] : 32'd0;
    assign busy       = (tag_vld_q != {NSTG{1'b0}}) | fifo_nonempty_s;
    assign drained    = drained_q;

endmodule

// File: tb/tb_idct_mul_sched.sv
// Directed self-checking bench for idct_mul_sched (NREQ=4, MUL_LAT=2).
// A two-stage behavioural multiplier stands in for the wrapper:
// P = bits [47:16] of a*b, XORed with the precision code so that the code
// is visible in the product. Inputs are driven 1ns after the rising edge,
// and outputs are checked 3ns after it.
module tb_idct_mul_sched;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 3;

    logic              clk = 1'b0;
    logic              rstP;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*DW-1:0] req_a, req_b;
    logic [NREQ*3-1:0] req_mode;
    logic              flush;
    logic [DW-1:0]     mul_a, mul_b;
    logic [2:0]        mul_state;
    logic [8:0]        mul_count0;
    logic [31:0]       mul_p;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_p;
    logic              busy, drained;

    int tests = 0;
    int fails = 0;
    int outst = 0;
    int max_outst = 0;

    always #5 clk = ~clk;

    idct_mul_sched #(.NREQ(NREQ), .DATA_PATH_BITWIDTH(DW), .MUL_LAT(2), .IDW(IDW)) dut (
        .clk(clk), .rstP(rstP),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
        .flush(flush),
        .mul_a(mul_a), .mul_b(mul_b), .mul_state(mul_state), .mul_count0(mul_count0),
        .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .busy(busy), .drained(drained)
    );

    // Wrapper stand-in: input register then output register.
    logic [31:0] m_a, m_b;
    logic [2:0]  m_s;
    function automatic logic [31:0] pmodel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] s);
        logic [63:0] pr;
        pr = {32'd0, a} * {32'd0, b};
        return pr[47:16] ^ {29'd0, s};
    endfunction
    always @(posedge clk) begin
        m_a   <= mul_a;
        m_b   <= mul_b;
        m_s   <= mul_state;
        mul_p <= pmodel(m_a, m_b, m_s);
    end

    // Outstanding handshakes not yet consumed; must never exceed the FIFO depth.
    always @(posedge clk) begin
        int hs, pp, nxt;
        hs  = (|(req_valid & req_ready)) ? 1 : 0;
        pp  = (rsp_valid & rsp_ready) ? 1 : 0;
        nxt = outst + hs - pp;
        if (rstP) begin
            outst     <= 0;
            max_outst <= 0;
        end else begin
            outst     <= nxt;
            max_outst <= (nxt > max_outst) ? nxt : max_outst;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstP      = 1'b1;
        req_valid = '0;
        flush     = 1'b0;
        tick();
        tick();
        rstP      = 1'b0;
    endtask

    // Wait (bounded) until the pipe empties, then let the FSM settle in IDLE.
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            tick();
            #2;
            n++;
        end
        check("drain_timeout", 64'(busy), 64'(0));
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_rdy;
        rstP = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_mode = '0;
        flush = 1'b0; rsp_ready = 1'b1;
        do_reset();

        // Reset values
        #2;
        check("rst_req_ready",  64'(req_ready),  64'(0));
        check("rst_mul_a",      64'(mul_a),      64'(0));
        check("rst_mul_b",      64'(mul_b),      64'(0));
        check("rst_mul_state",  64'(mul_state),  64'(0));
        check("rst_mul_count0", 64'(mul_count0), 64'(0));
        check("rst_rsp_valid",  64'(rsp_valid),  64'(0));
        check("rst_rsp_id",     64'(rsp_id),     64'(0));
        check("rst_rsp_p",      64'(rsp_p),      64'(0));
        check("rst_busy",       64'(busy),       64'(0));
        check("rst_drained",    64'(drained),    64'(0));
        tick();

        // Single op from requester 2
        req_a[2*DW +: DW] = 32'h0003_0000;
        req_b[2*DW +: DW] = 32'h0002_0000;
        req_mode[6 +: 3]  = 3'b011;
        req_valid = 4'b0100;
        #2; check("t1_idle_noready", 64'(req_ready), 64'(0));
        tick(); #2; check("t1_grant", 64'(req_ready), 64'(4'b0100));
        tick(); req_valid = 4'b0000; #2;
        check("t1_mul_a",     64'(mul_a),      64'(32'h0003_0000));
        check("t1_mul_b",     64'(mul_b),      64'(32'h0002_0000));
        check("t1_mul_state", 64'(mul_state),  64'(3'b011));
        check("t1_count0",    64'(mul_count0), 64'(0));
        check("t1_busy",      64'(busy),       64'(1));
        tick(); #2; check("t1_state_idle", 64'(mul_state), 64'(0));
        tick(); #2; check("t1_rsp_early", 64'(rsp_valid), 64'(0));
        tick(); #2;
        check("t1_rsp_valid", 64'(rsp_valid), 64'(1));
        check("t1_rsp_id",    64'(rsp_id),    64'(2));
        check("t1_rsp_p",     64'(rsp_p),     64'(32'h0006_0003));
        tick(); #2; check("t1_rsp_popped", 64'(rsp_valid), 64'(0));
        wait_idle();

        // Mode pass-through, requesters 1 and 3 alternating (rr_ptr is 3)
        req_a[1*DW +: DW] = 32'h0001_0000; req_b[1*DW +: DW] = 32'h0005_0000; req_mode[3 +: 3] = 3'b010;
        req_a[3*DW +: DW] = 32'h0007_0000; req_b[3*DW +: DW] = 32'h0002_0000; req_mode[9 +: 3] = 3'b100;
        req_valid = 4'b1010;
        tick(); #2; check("t2_rdy0", 64'(req_ready), 64'(4'b1000));
        tick(); #2;
        check("t2_rdy1",   64'(req_ready),  64'(4'b0010));
        check("t2_state0", 64'(mul_state),  64'(3'b100));
        check("t2_mul_a0", 64'(mul_a),      64'(32'h0007_0000));
        check("t2_cnt0",   64'(mul_count0), 64'(0));
        tick(); #2;
        check("t2_rdy2",   64'(req_ready), 64'(4'b1000));
        check("t2_state1", 64'(mul_state), 64'(3'b010));
        tick(); #2;
        check("t2_rdy3",   64'(req_ready), 64'(4'b0010));
        check("t2_state2", 64'(mul_state), 64'(3'b100));
        tick(); req_valid = 4'b0000; #2;
        check("t2_state3",    64'(mul_state),  64'(3'b010));
        check("t2_cnt3",      64'(mul_count0), 64'(3));
        check("t2_rsp_valid", 64'(rsp_valid),  64'(1));
        check("t2_rsp_id0",   64'(rsp_id),     64'(3));
        check("t2_rsp_p0",    64'(rsp_p),      64'(32'h000E_0004));
        tick(); #2;
        check("t2_state_off", 64'(mul_state), 64'(3'b000));
        check("t2_rsp_id1",   64'(rsp_id),    64'(1));
        check("t2_rsp_p1",    64'(rsp_p),     64'(32'h0005_0002));
        wait_idle();

        // All four valid continuously (rr_ptr is 2); count0 wraps at the 65th op
        req_valid = 4'b1111;
        for (int i = 0; i < 66; i++) begin
            tick(); #2;
            exp_rdy = 4'b0001 << ((2 + i) % 4);
            check("t3_rr", 64'(req_ready), 64'(exp_rdy));
            if (i > 0) check("t3_count0", 64'(mul_count0), 64'((i - 1) % 64));
        end
        tick(); req_valid = 4'b0000; #2;
        check("t3_count0_last", 64'(mul_count0), 64'(1));
        wait_idle();

        // Backpressure from reset
        do_reset();
        rsp_ready = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            req_a[j*DW +: DW] = 32'(j + 1) << 16;
            req_b[j*DW +: DW] = 32'h0001_0000;
            req_mode[j*3 +: 3] = 3'b010;
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick(); #2;
            exp_rdy = 4'b0001 << i;
            check("t4_grant", 64'(req_ready), 64'(exp_rdy));
        end
        for (int i = 0; i < 6; i++) begin
            tick(); #2;
            check("t4_stalled", 64'(req_ready), 64'(0));
        end
        check("t4_rsp_valid", 64'(rsp_valid), 64'(1));
        check("t4_head_id",   64'(rsp_id),    64'(0));
        check("t4_head_p",    64'(rsp_p),     64'(32'h0001_0002));
        for (int i = 0; i < 4; i++) begin
            tick(); rsp_ready = 1'b1; #2;
            exp_rdy = 4'b0001 << i;
            check("t4_rsp_id",  64'(rsp_id),    64'(i));
            check("t4_rsp_p",   64'(rsp_p),     64'(((i + 1) << 16) | 2));
            check("t4_resume",  64'(req_ready), 64'(exp_rdy));
        end
        check("t4_max_outstanding", 64'(max_outst), 64'(4));
        req_valid = 4'b0000;
        wait_idle();

        // Flush with three ops in flight
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick(); #2;
            exp_rdy = 4'b0001 << i;
            check("t5_grant", 64'(req_ready), 64'(exp_rdy));
        end
        tick(); flush = 1'b1; #2; check("t5_flush_nogrant", 64'(req_ready), 64'(0));
        tick(); flush = 1'b0; #2;
        check("t5_flush_rdy", 64'(req_ready), 64'(0));
        check("t5_rsp_id0",   64'(rsp_id),    64'(0));
        tick(); #2; check("t5_rsp_id1", 64'(rsp_id), 64'(1));
        tick(); #2; check("t5_rsp_id2", 64'(rsp_id), 64'(2));
        tick(); #2;
        check("t5_empty_busy",    64'(busy),      64'(0));
        check("t5_drained_early", 64'(drained),   64'(0));
        check("t5_rdy_c8",        64'(req_ready), 64'(0));
        tick(); #2;
        check("t5_drained",   64'(drained),   64'(1));
        check("t5_idle_rdy",  64'(req_ready), 64'(0));
        tick(); #2;
        check("t5_drained_once", 64'(drained),   64'(0));
        check("t5_rerun_grant",  64'(req_ready), 64'(4'b1000));
        tick(); req_valid = 4'b0000;
        wait_idle();

        // Reset with two ops in flight and two in the FIFO
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) tick();
        #2;
        check("t6_pre_valid", 64'(rsp_valid), 64'(1));
        check("t6_pre_busy",  64'(busy),      64'(1));
        #1; rstP = 1'b1; req_valid = 4'b0000;
        tick(); rstP = 1'b0; rsp_ready = 1'b1; #2;
        check("t6_req_ready",  64'(req_ready),  64'(0));
        check("t6_mul_a",      64'(mul_a),      64'(0));
        check("t6_mul_state",  64'(mul_state),  64'(0));
        check("t6_mul_count0", 64'(mul_count0), 64'(0));
        check("t6_rsp_id",     64'(rsp_id),     64'(0));
        check("t6_rsp_p",      64'(rsp_p),      64'(0));
        check("t6_busy",       64'(busy),       64'(0));
        check("t6_drained",    64'(drained),    64'(0));
        for (int i = 0; i < 8; i++) begin
            check("t6_no_stale", 64'(rsp_valid), 64'(0));
            tick(); #2;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
